decode_queue: RTL and testbench

Parametrised decode buffer between fetch and the D/E pipeline register. Accepts fetched instructions over a valid/ready handshake, decodes each one into the 15-bit control bundle in the cycle it is written, and stores instruction, PC and controls in a DEPTH-entry circular queue. The head entry drives downstream decode outputs, which isolates fetch stalls from execute stalls and removes the decoder from the D-stage critical path.

---
 rtl/decode_queue_if.sv | 25 ++
 rtl/decode_queue.sv | 91 +++++++++
 tb/tb_decode_queue.sv | 135 +++++++++++++
 3 files changed

// File: rtl/decode_queue_if.sv
// decode_queue_if: fetch-to-decode handshake bundle; master = fetch/consumer side, slave = queue
interface decode_queue_if #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [31:0]              in_instr;
  logic [PC_W-1:0]          in_pc;
  logic                     out_valid;
  logic                     out_ready;
  logic [31:0]              out_instr;
  logic [PC_W-1:0]          out_pc;
  logic [14:0]              out_ctrl;
  logic [$clog2(DEPTH):0]   count;
  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_ctrl, count
  );
  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_ctrl, count
  );
endinterface

// File: rtl/decode_queue.sv
// decode_queue: DEPTH-entry circular buffer that decodes each fetched word into a 15-bit control bundle on write.
// Ports: clk, rst (sync, active-high); q (decode_queue_if.slave): flush, in_valid/in_ready/in_instr/in_pc,
// out_valid/out_ready/out_instr/out_pc/out_ctrl, count. Optional macro CP0_DECODE_EN enables mfc0/mtc0/eret decode.
module decode_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input logic          clk,
  input logic          rst,
  decode_queue_if.slave q
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [14:0] RW = 15'h4000, RD = 15'h2000, AS = 15'h1000, BR = 15'h0800,
                          MW = 15'h0400, MR = 15'h0200, JP = 15'h0100, JL = 15'h0080,
                          JG = 15'h0040, BK = 15'h0020, SC = 15'h0010, RS = 15'h0001;
`ifdef CP0_DECODE_EN
  localparam logic [14:0] ER = 15'h0008, CR = 15'h0004, CW = 15'h0002;
`endif
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     cnt;
  logic [31:0]     mem_instr [DEPTH];
  logic [PC_W-1:0] mem_pc    [DEPTH];
  logic [14:0]     mem_ctrl  [DEPTH];
  logic            push, pop;
  logic [14:0]     dec;
  logic [5:0]      op, fn;
  logic [4:0]      rt;
  assign op = q.in_instr[31:26];
  assign fn = q.in_instr[5:0];
  assign rt = q.in_instr[20:16];
  assign q.in_ready  = cnt != FULL;
  assign q.out_valid = cnt != '0;
  assign q.count     = cnt;
  assign push = q.in_valid & q.in_ready & ~q.flush;
  assign pop  = q.out_valid & q.out_ready & ~q.flush;
  // empty queue must never expose a stale slot
  assign q.out_instr = q.out_valid ? mem_instr[rd_ptr] : '0;
  assign q.out_pc    = q.out_valid ? mem_pc[rd_ptr]    : '0;
  assign q.out_ctrl  = q.out_valid ? mem_ctrl[rd_ptr]  : '0;
  always_comb begin
    dec = RS;
    case (op)
      6'h00: case (fn)
        6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
        6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
        6'h2a, 6'h2b:                                   dec = RW | RD;
        6'h11, 6'h13, 6'h18, 6'h19, 6'h1a, 6'h1b:       dec = '0;
        6'h08:                                          dec = JP | JG;
        6'h09:                                          dec = RW | RD | JP | JL | JG;
        6'h0c:                                          dec = SC;
        6'h0d:                                          dec = BK;
        default:                                        dec = RS;
      endcase
      6'h01: dec = (rt == 5'b00000 || rt == 5'b00001) ? BR :
                   (rt == 5'b10000 || rt == 5'b10001) ? RW | RD | BR | JL : RS;
      6'h02: dec = JP;
      6'h03: dec = RW | RD | JP | JL;
      6'h04, 6'h05, 6'h06, 6'h07: dec = BR;
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f: dec = RW | AS;
      6'h20, 6'h21, 6'h23, 6'h24, 6'h25: dec = RW | AS | MR;
      6'h28, 6'h29, 6'h2b: dec = AS | MW;
`ifdef CP0_DECODE_EN
      6'h10: dec = (q.in_instr == 32'h4200_0018) ? ER :
                   (q.in_instr[25:21] == 5'b00100 && q.in_instr[10:3] == '0) ? CW :
                   (q.in_instr[25:21] == 5'b00000 && q.in_instr[10:3] == '0) ? RW | CR : RS;
`else
      6'h10: dec = RS;
`endif
      default: dec = RS;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst || q.flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      cnt <= cnt + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      mem_instr[wr_ptr] <= q.in_instr;
      mem_pc[wr_ptr]    <= q.in_pc;
      mem_ctrl[wr_ptr]  <= dec;
    end
  end
endmodule

// File: tb/tb_decode_queue.sv
// tb_decode_queue: scoreboard bench for decode_queue with hand-computed control bundles
module tb_decode_queue;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;
  decode_queue_if #(.DEPTH(4), .PC_W(32)) q();
  decode_queue #(.DEPTH(4), .PC_W(32)) dut (.clk(clk), .rst(rst), .q(q));
  int checks = 0;
  int errors = 0;
  logic [78:0] sb[$];
`ifdef CP0_DECODE_EN
  localparam logic [14:0] ERET_C = 15'h0008, MTC0_C = 15'h0002, MFC0_C = 15'h4004;
`else
  localparam logic [14:0] ERET_C = 15'h0001, MTC0_C = 15'h0001, MFC0_C = 15'h0001;
`endif
  logic [31:0] sw_i [18] = '{32'h0060F809, 32'h04020000, 32'hFC000000, 32'h8C410004, 32'hAC410004,
                             32'h08000010, 32'h0C000010, 32'h10220003, 32'h04100003, 32'h00221821,
                             32'h00220018, 32'h03E00008, 32'h0000000D, 32'h0000000C, 32'h00000001,
                             32'h42000018, 32'h40806000, 32'h40026000};
  logic [14:0] sw_c [18] = '{15'h61C0, 15'h0001, 15'h0001, 15'h5200, 15'h1400,
                             15'h0100, 15'h6180, 15'h0800, 15'h6880, 15'h6000,
                             15'h0000, 15'h0140, 15'h0020, 15'h0010, 15'h0001,
                             ERET_C, MTC0_C, MFC0_C};
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, act, want);
    end
  endtask
  task automatic cyc(input logic iv, input logic [31:0] ins, input logic [31:0] p,
                     input logic [14:0] c, input logic ordy, input logic fl);
    @(posedge clk);
    #1;
    q.in_valid  = iv;
    q.in_instr  = ins;
    q.in_pc     = p;
    q.out_ready = ordy;
    q.flush     = fl;
    @(negedge clk);
    if (fl) sb.delete();
    else if (iv && q.in_ready) sb.push_back({ins, p, c});
  endtask
  task automatic drain();
    for (int k = 0; k < 40 && sb.size() != 0; k++) cyc(1'b0, '0, '0, '0, 1'b1, 1'b0);
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d entries left, want 0", sb.size());
      sb.delete();
    end
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("drain_count", 32'(q.count), 0);
  endtask
  initial begin
    rst = 1'b1;
    q.flush = 1'b0;
    q.in_valid = 1'b0;
    q.in_instr = '0;
    q.in_pc = '0;
    q.out_ready = 1'b0;
    fork
      forever begin
        logic [78:0] e;
        @(negedge clk);
        if (!rst && !q.flush && q.out_valid && q.out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL pop_unexpected: got instr %h, want no output", q.out_instr);
          end else begin
            e = sb.pop_front();
            chk("pop_instr", q.out_instr, e[78:47]);
            chk("pop_pc", q.out_pc, e[46:15]);
            chk("pop_ctrl", 32'(q.out_ctrl), 32'(e[14:0]));
          end
        end
      end
    join_none
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(q.out_valid), 0);
    chk("rst_in_ready", 32'(q.in_ready), 1);
    chk("rst_count", 32'(q.count), 0);
    chk("rst_out_ctrl", 32'(q.out_ctrl), 0);
    chk("rst_out_instr", q.out_instr, 0);
    chk("rst_out_pc", q.out_pc, 0);
    cyc(1'b1, 32'h34020005, 32'hBFC00000, 15'h5000, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("ori_out_valid", 32'(q.out_valid), 1);
    chk("ori_out_ctrl", 32'(q.out_ctrl), 32'h5000);
    chk("ori_count", 32'(q.count), 1);
    drain();
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 32'h24010000 + 32'(i), 32'h100 + 32'(4 * i), 15'h5000, 1'b0, 1'b0);
      if (i == 4) begin
        chk("full_in_ready", 32'(q.in_ready), 0);
        chk("full_count", 32'(q.count), 4);
      end
    end
    chk("full_head_stable", q.out_instr, 32'h24010000);
    cyc(1'b1, 32'h24010005, 32'h200, 15'h5000, 1'b1, 1'b0);
    chk("full_pop_no_push_count", 32'(q.count), 4);
    cyc(1'b1, 32'h24010005, 32'h200, 15'h5000, 1'b0, 1'b0);
    chk("after_pop_in_ready", 32'(q.in_ready), 1);
    chk("after_pop_count", 32'(q.count), 3);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("wrap_refill_count", 32'(q.count), 4);
    drain();
    cyc(1'b1, 32'h00221821, 32'h300, 15'h6000, 1'b0, 1'b0);
    cyc(1'b1, 32'h8C410004, 32'h304, 15'h5200, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("pushpop_count", 32'(q.count), 1);
    drain();
    for (int i = 0; i < 3; i++) cyc(1'b1, 32'h3C010000 + 32'(i), 32'h400 + 32'(4 * i), 15'h5000, 1'b0, 1'b0);
    cyc(1'b1, 32'h3C01DEAD, 32'h40C, 15'h5000, 1'b0, 1'b1);
    chk("flush_in_ready", 32'(q.in_ready), 1);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("flush_count", 32'(q.count), 0);
    chk("flush_out_valid", 32'(q.out_valid), 0);
    chk("flush_out_ctrl", 32'(q.out_ctrl), 0);
    chk("flush_out_instr", q.out_instr, 0);
    cyc(1'b1, 32'h34030007, 32'h500, 15'h5000, 1'b0, 1'b0);
    cyc(1'b0, '0, '0, '0, 1'b0, 1'b0);
    chk("post_flush_head", q.out_instr, 32'h34030007);
    chk("post_flush_count", 32'(q.count), 1);
    drain();
    for (int i = 0; i < 18; i++) cyc(1'b1, sw_i[i], 32'h600 + 32'(4 * i), sw_c[i], 1'b1, 1'b0);
    drain();
    chk("scoreboard_empty", 32'(sb.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
